// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register IDs, status codes,
// and the decode/writeback status FSM state type.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register IDs
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    // Processor status codes
    localparam logic [1:0] SAOK = 2'd0;
    localparam logic [1:0] SHLT = 2'd1;
    localparam logic [1:0] SADR = 2'd2;
    localparam logic [1:0] SINS = 2'd3;

    // RUN while status is AOK; STOP is sticky until reset
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } state_e;

endpackage

// File: rtl/decode_writeback_if.sv
// Bus between fetch/execute/memory (master) and the decode/writeback stage (slave).
interface decode_writeback_if;
    import y86_pkg::*;

    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [1:0]  stat_in;
    logic        wb_valid;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [1:0]  stat;
    logic        halted;

    modport master (
        output icode, rA, rB, cnd, valE, valM, stat_in, wb_valid,
        input  srcA, srcB, dstE, dstM, valA, valB, stat, halted
    );

    modport slave (
        input  icode, rA, rB, cnd, valE, valM, stat_in, wb_valid,
        output srcA, srcB, dstE, dstM, valA, valB, stat, halted
    );

endinterface

// File: rtl/y86_regfile.sv
// Architectural register file: NREGS x 64, two async read ports plus a debug
// port, two write ports where M overrides E on a shared destination.
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'd1024,
    parameter int          NREGS      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    output logic [63:0] dbg_data
);

    logic [63:0] regs_q [NREGS];
    logic [63:0] regs_d [NREGS];

    // Read ports: pre-edge contents, no bypass; IDs outside the file read as 0
    always_comb begin
        val_a    = (int'(src_a) < NREGS)    ? regs_q[src_a]    : '0;
        val_b    = (int'(src_b) < NREGS)    ? regs_q[src_b]    : '0;
        dbg_data = (int'(dbg_addr) < NREGS) ? regs_q[dbg_addr] : '0;
    end

    // Next register contents: E write first, then M so popq %rsp keeps valM
    always_comb begin
        // NOTE: start from the current contents so every path assigns regs_d and no latch is inferred.
        regs_d = regs_q;
        if (we && int'(dst_e) < NREGS) regs_d[dst_e] = val_e;
        if (we && int'(dst_m) < NREGS) regs_d[dst_m] = val_m;
    end

    // Storage update with synchronous reset to the architectural reset image
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this file is flops, not SRAM, and software relies on zeroed registers and a valid %rsp, so every entry is reset.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == int'(RRSP)) ? STACK_INIT : '0;
            end
        end else begin
            // NOTE: non-blocking assignment so all flops update together from pre-edge values.
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: register ID selection, sticky status FSM,
// and the architectural register file.
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'd1024,
    parameter int          NREGS      = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_writeback_if.slave    wb,
    input  logic [3:0]           dbg_addr,
    output logic [63:0]          dbg_data
);

    state_e     state_q, state_d;
    logic [1:0] stat_q, stat_d;
    logic       commit;

    // Source/destination ID selection from the fetched instruction
    always_comb begin
        wb.srcA = RNONE;
        wb.srcB = RNONE;
        wb.dstE = RNONE;
        wb.dstM = RNONE;
        case (wb.icode)
            IRRMOVQ: begin
                wb.srcA = wb.rA;
                wb.dstE = wb.cnd ? wb.rB : RNONE;
            end
            IIRMOVQ: wb.dstE = wb.rB;
            IRMMOVQ: begin
                wb.srcA = wb.rA;
                wb.srcB = wb.rB;
            end
            IMRMOVQ: begin
                wb.srcB = wb.rB;
                wb.dstM = wb.rA;
            end
            IOPQ: begin
                wb.srcA = wb.rA;
                wb.srcB = wb.rB;
                wb.dstE = wb.rB;
            end
            ICALL: begin
                wb.srcB = RRSP;
                wb.dstE = RRSP;
            end
            IRET: begin
                wb.srcA = RRSP;
                wb.srcB = RRSP;
                wb.dstE = RRSP;
            end
            IPUSHQ: begin
                wb.srcA = wb.rA;
                wb.srcB = RRSP;
                wb.dstE = RRSP;
            end
            IPOPQ: begin
                wb.srcA = RRSP;
                wb.srcB = RRSP;
                wb.dstE = RRSP;
                wb.dstM = wb.rA;
            end
            default: ;
        endcase
    end

    // Status FSM next state: first non-AOK completion latches its status
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        commit  = 1'b0;
        if (wb.wb_valid && state_q == ST_RUN) begin
            if (wb.stat_in == SAOK) begin
                commit = 1'b1;
            end else begin
                state_d = ST_STOP;
                stat_d  = wb.stat_in;
            end
        end
    end

    // Status FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            stat_q  <= SAOK;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
        end
    end

    assign wb.stat   = stat_q;
    assign wb.halted = (state_q == ST_STOP);

    y86_regfile #(
        .STACK_INIT (STACK_INIT),
        .NREGS      (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (commit),
        .dst_e    (wb.dstE),
        .val_e    (wb.valE),
        .dst_m    (wb.dstM),
        .val_m    (wb.valM),
        .src_a    (wb.srcA),
        .src_b    (wb.srcB),
        .dbg_addr (dbg_addr),
        .val_a    (wb.valA),
        .val_b    (wb.valB),
        .dbg_data (dbg_data)
    );

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- SEQ-processor stage directly downstream of instruction fetch.
- Consumes icode/rA/rB from fetch and selects source and destination register IDs.
- Provides valA/valB to execute from the 15x64-bit architectural register file.
- Commits valE/valM from execute/memory into the register file at the end of each instruction cycle.
- Owns the sticky processor status that freezes architectural state after halt or error.

Parameters:
- STACK_INIT, 64'd1024, reset value of %rsp (reg 4); all other registers reset to 0.
- NREGS, 15, number of architectural registers (IDs 0..14; ID 4'hF = RNONE).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- icode  in  4  instruction code from fetch
- rA  in  4  register A field from fetch
- rB  in  4  register B field from fetch
- cnd  in  1  condition outcome from execute (cmovXX)
- valE  in  64  ALU result to write back
- valM  in  64  memory read data to write back
- stat_in  in  2  status of current instruction: 0 AOK, 1 HLT, 2 ADR, 3 INS
- wb_valid  in  1  current instruction complete; commit on this edge
- srcA  out  4  selected A source ID
- srcB  out  4  selected B source ID
- dstE  out  4  selected E destination ID
- dstM  out  4  selected M destination ID
- valA  out  64  register[srcA], 0 if RNONE
- valB  out  64  register[srcB], 0 if RNONE
- stat  out  2  sticky processor status
- halted  out  1  stat != AOK
- dbg_addr  in  4  debug read address
- dbg_data  out  64  register[dbg_addr], 0 if RNONE

Behaviour:
- Decode is combinational from icode/rA/rB/cnd. Reset does not gate decode.
- srcA = rA for RRMOVQ(2), RMMOVQ(4), OPQ(6), PUSHQ(10); 4 for POPQ(11) and RET(9); else F.
- srcB = rB for OPQ, RMMOVQ, MRMOVQ(5); 4 for PUSHQ, POPQ, CALL(8), RET; else F.
- dstE = rB for IRMOVQ(3), OPQ, and RRMOVQ with cnd=1. RRMOVQ with cnd=0 gives F. dstE = 4 for PUSHQ, POPQ, CALL, RET; else F.
- dstM = rA for MRMOVQ and POPQ; else F.
- Reads are asynchronous, zero latency, from pre-edge contents. There is no write-to-read bypass within a cycle.
- Write rule: at a rising clk edge with wb_valid=1, rst=0, stat=AOK and stat_in=AOK:
  - regs[dstE] <= valE if dstE != F;
  - regs[dstM] <= valM if dstM != F.
- If dstE == dstM != F (popq %rsp), valM wins.
- Writes to ID F are discarded. Register IDs 0..14 are all writable.
- Status FSM has states RUN (stat=AOK) and STOP (stat=HLT/ADR/INS).
  - RUN -> STOP at an edge with wb_valid=1 and stat_in != AOK; stat <= stat_in.
  - The faulting instruction's writes are suppressed.
  - STOP is sticky. All writes are suppressed and stat is held until rst.
  - wb_valid=0 holds all state regardless of other inputs.
- Reset at the rising edge with rst=1:
  - all regs <= 0 except reg 4 <= STACK_INIT;
  - stat <= AOK; halted <= 0.
  - Reset overrides a coincident wb_valid. Reset mid-program discards the in-flight writeback.
  - Outputs after reset: valA/valB/dbg_data reflect reset contents (e.g. srcA=4 gives STACK_INIT).
- Widths: all data 64-bit, no arithmetic performed here; IDs are 4-bit.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants IHALT..IPOPQ (0..11);
  - RNONE=4'hF and RRSP=4'h4;
  - stat encodings SAOK/SHLT/SADR/SINS.
  - The same constants are used by fetch, execute and memory.
- Sub-module y86_regfile: 15x64 storage, reset logic, two async read ports plus debug port, two write ports with M-over-E priority.
- decode_writeback holds the ID-select logic and the status FSM, and instantiates y86_regfile.

Test Plan:
- Reset: pulse rst, then set icode=11, rA=0. Expect srcA=srcB=4, valA=valB=1024, stat=0; dbg reads of regs 0..14 give 0 except reg 4 = 1024.
- irmovq: icode=3, rB=2, valE=16, wb_valid=1, one edge. Expect dbg_addr=2 -> 16, dstE=2, dstM=F; no other register changes.
- cmov: icode=2, rA=2, rB=3, valE=16.
  - cnd=0: dstE=F, reg 3 unchanged.
  - cnd=1: dstE=3, reg 3 = 16 after the edge.
- popq %rsp: icode=11, rA=4, valE=1032, valM=0xDEAD, wb_valid=1. Expect reg 4 = 0xDEAD (M priority).
- Halt: icode=0, stat_in=1, wb_valid=1. Expect stat=1, halted=1. A following irmovq rB=0 valE=5 with stat_in=0 leaves reg 0 unchanged. After rst, stat=0.
- Reset mid-op: rst=1 and wb_valid=1 with icode=3, rB=1, valE=7 on the same edge. Expect reg 1 = 0; wb_valid=0 for 3 edges leaves all registers unchanged.
